spi_tx_shifter: RTL



---
 rtl/spi_tx_shifter.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_tx_shifter.sv
// SPI master transmit shift stage: loads one word, then drives CS_N/SCLK/MOSI with selectable CPOL/CPHA and bit order.
// Optional feature macro SPI_TX_HOLD_REG_EN adds a one-word holding register for gapless back-to-back words.
module spi_tx_shifter #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              TE,
  input  logic              SENDER_WRITE,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic              SENDER_EMPTY_STATE,
  output logic              SCLK,
  output logic              MOSI,
  output logic              CS_N,
  output logic              BUSY,
  output logic              DONE
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t            state, state_d;
  logic [DIV_W-1:0]  div_cnt, div_d;
  logic [BIT_W-1:0]  bit_cnt, bit_d;
  logic [DATA_W-1:0] sreg, sreg_d;
  logic              sclk_d, mosi_d, cs_n_d, busy_d, done_d, empty_d;
  logic              wrap, lead_edge, advance, load_now;
  logic [DATA_W-1:0] load_word;

`ifdef SPI_TX_HOLD_REG_EN
  logic [DATA_W-1:0] hold, hold_d;
  logic              hold_full, hold_full_d;
`endif

  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] shifted(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
  endfunction

  always_comb begin
    state_d   = state;
    div_d     = div_cnt;
    bit_d     = bit_cnt;
    sreg_d    = sreg;
    sclk_d    = SCLK;
    mosi_d    = MOSI;
    cs_n_d    = CS_N;
    busy_d    = BUSY;
    done_d    = 1'b0;
    empty_d   = SENDER_EMPTY_STATE;
    advance   = 1'b0;
    load_now  = 1'b0;
    load_word = DATA_IN;
`ifdef SPI_TX_HOLD_REG_EN
    hold_d      = hold;
    hold_full_d = hold_full;
`endif
    wrap      = (div_cnt == DIV_MAX);
    lead_edge = (SCLK == CPOL);

    case (state)
      IDLE: begin
`ifdef SPI_TX_HOLD_REG_EN
        if (TE && hold_full) begin
          load_now    = 1'b1;
          load_word   = hold;
          hold_full_d = 1'b0;
        end else if (TE && SENDER_WRITE) begin
          load_now = 1'b1;
        end
`else
        if (TE && SENDER_WRITE) load_now = 1'b1;
`endif
        if (load_now) begin
          state_d = LEAD;
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = CPOL;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          empty_d = 1'b0;
        end
      end
      LEAD: begin
        div_d = wrap ? '0 : div_cnt + 1'b1;
        if (wrap) begin
          // first SCLK edge is always a leading edge
          state_d = SHIFT;
          sclk_d  = ~SCLK;
          advance = CPHA;
        end
      end
      SHIFT: begin
        div_d = wrap ? '0 : div_cnt + 1'b1;
        if (wrap) begin
          sclk_d = ~SCLK;
          if (lead_edge) begin
            advance = CPHA;
          end else if (bit_cnt == BIT_LAST) begin
            bit_d = '0;
`ifdef SPI_TX_HOLD_REG_EN
            // chain the held word straight into the next frame, CS_N stays low
            if (hold_full) begin
              load_now    = 1'b1;
              load_word   = hold;
              hold_full_d = 1'b0;
              done_d      = 1'b1;
            end else begin
              state_d = TRAIL;
            end
`else
            state_d = TRAIL;
`endif
          end else begin
            bit_d   = bit_cnt + 1'b1;
            advance = !CPHA;
          end
        end
      end
      TRAIL: begin
        div_d = wrap ? '0 : div_cnt + 1'b1;
        if (wrap) begin
          state_d = IDLE;
          sclk_d  = CPOL;
          mosi_d  = 1'b0;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          empty_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      mosi_d = first_bit(sreg);
      sreg_d = shifted(sreg);
    end
    // CPHA=0 presents the first bit at load; CPHA=1 waits for the leading edge
    if (load_now) begin
      sreg_d = CPHA ? load_word : shifted(load_word);
      if (!CPHA) mosi_d = first_bit(load_word);
    end

`ifdef SPI_TX_HOLD_REG_EN
    if (TE && SENDER_WRITE && !hold_full && state != IDLE) begin
      hold_d      = DATA_IN;
      hold_full_d = 1'b1;
    end
`endif

    if (!TE && state != IDLE) begin
      state_d = IDLE;
      div_d   = '0;
      bit_d   = '0;
      sclk_d  = CPOL;
      mosi_d  = 1'b0;
      cs_n_d  = 1'b1;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      empty_d = 1'b1;
    end

`ifdef SPI_TX_HOLD_REG_EN
    if (!TE) hold_full_d = 1'b0;
    empty_d = !hold_full_d;
`endif
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state              <= IDLE;
      div_cnt            <= '0;
      bit_cnt            <= '0;
      sreg               <= '0;
      SCLK               <= CPOL;
      MOSI               <= 1'b0;
      CS_N               <= 1'b1;
      BUSY               <= 1'b0;
      DONE               <= 1'b0;
      SENDER_EMPTY_STATE <= 1'b1;
    end else begin
      state              <= state_d;
      div_cnt            <= div_d;
      bit_cnt            <= bit_d;
      sreg               <= sreg_d;
      SCLK               <= sclk_d;
      MOSI               <= mosi_d;
      CS_N               <= cs_n_d;
      BUSY               <= busy_d;
      DONE               <= done_d;
      SENDER_EMPTY_STATE <= empty_d;
    end
  end

`ifdef SPI_TX_HOLD_REG_EN
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      hold      <= hold_d;
      hold_full <= hold_full_d;
    end
  end
`endif

endmodule
